// File: rtl/prog_ram_arbiter.sv
// prog_ram_arbiter: single-port synchronous-read program RAM shared by display, CPU fetch and bit editor
module prog_ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic                       disp_req,
  input  logic [ADDR_W-1:0]          disp_addr,
  output logic                       disp_ack,
  output logic [DATA_W-1:0]          disp_data,
  input  logic                       cpu_req,
  input  logic [ADDR_W-1:0]          cpu_addr,
  output logic                       cpu_ack,
  output logic [DATA_W-1:0]          cpu_data,
  input  logic                       ed_req,
  input  logic [ADDR_W-1:0]          ed_addr,
  input  logic [$clog2(DATA_W)-1:0]  ed_bit,
  input  logic                       ed_val,
  output logic                       ed_ack,
  output logic [1:0]                 grant_id
);
  typedef enum logic [1:0] {IDLE, RD, RMW_RD, RMW_WR} state_t;
  state_t st, st_n;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] w_q, w_new;
  logic [ADDR_W-1:0] addr, a_q;
  logic [$clog2(DATA_W)-1:0] b_q;
  logic [1:0] win, own;
  logic other, last_disp, v_q;

  always_ff @(posedge clk)
    if (!rst) st <= IDLE;
    else st <= st_n;

  // Acks are masked by rst so a reset landing in the ack cycle produces no pulse.
  always_comb begin
    other = mode ? ed_req : cpu_req;
    win = (disp_req && !(last_disp && other)) ? 2'd1 : other ? (mode ? 2'd3 : 2'd2) : 2'd0;
    addr = win == 2'd1 ? disp_addr : win == 2'd2 ? cpu_addr : ed_addr;
    st_n = st == IDLE ? (win == 2'd0 ? IDLE : win == 2'd3 ? RMW_RD : RD) : st == RMW_RD ? RMW_WR : IDLE;
    w_new = w_q;
    w_new[b_q] = v_q;
    disp_ack = rst && st == RD && own == 2'd1;
    cpu_ack = rst && st == RD && own == 2'd2;
    ed_ack = rst && st == RMW_WR;
    grant_id = st == IDLE ? 2'd0 : own;
  end

  always_ff @(posedge clk)
    if (!rst) begin
      own <= 2'd0;
      last_disp <= 1'b0;
      disp_data <= '0;
      cpu_data <= '0;
    end else if (st == IDLE && win != 2'd0) begin
      own <= win;
      last_disp <= win == 2'd1;
      a_q <= addr;
      b_q <= ed_bit;
      v_q <= ed_val;
      w_q <= mem[addr];
      if (win == 2'd1) disp_data <= mem[addr];
      if (win == 2'd2) cpu_data <= mem[addr];
    end

  always_ff @(posedge clk)
    if (rst && st == RMW_WR) mem[a_q] <= w_new;
endmodule
